sub_64_bit_seq: RTL and testbench
=================================

Name: sub_64_bit_seq

Overview:
- Multi-cycle 64-bit two's-complement subtractor for the Y86 ALU; computes diff = a - b as a + ~b + 1, CHUNK bits per clock.
- Serves the SUBQ and compare path as the inverse of the 64-bit adder.
- Produces the difference plus Y86 condition flags ZF, SF and OF.
- Start/done handshake; operands are captured on start, so the caller may change them afterwards.

Parameters:
- WIDTH, 64, operand and result width in bits.
- CHUNK, 8, bits processed per cycle; must divide WIDTH. Number of RUN cycles N = WIDTH/CHUNK, which is 8 by default.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend, signed.
- b  input  WIDTH  subtrahend, signed.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- overflow  output  1  signed overflow (OF).
- zf  output  1  diff == 0.
- sf  output  1  diff[WIDTH-1].

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state goes to IDLE.
  - busy, done, diff, overflow, zf and sf all go to 0.
  - internal operand, carry and chunk-index registers clear.
  - Asserting reset mid-operation aborts with no done pulse. Operation resumes on the first edge after rst_n rises.
- States:
  - IDLE -> RUN: on an edge with start=1.
    - Latch a, ~b, carry=1 and idx=0.
    - busy=1 from this edge.
  - RUN: each edge processes chunk idx, bits [idx*CHUNK +: CHUNK].
    - Compute {c_out, s} = a_chunk + nb_chunk + carry.
    - Store s into the result shift/accumulator register; carry <= c_out; idx++.
    - Inputs a, b and start are ignored during RUN.
  - RUN -> DONE: on the edge that processes chunk N-1.
    - diff, zf, sf and overflow update on that same edge.
    - done=1 and busy=0 on that edge.
  - DONE: lasts exactly one cycle.
    - If start=1, go to RUN and latch new operands (back-to-back).
    - Otherwise go to IDLE.
- Latency: start sampled at edge E gives done high in the cycle after edge E+N (E+8 by default). Throughput is one operation per N+1 cycles.
- Flags, computed from the full result:
  - zf = (diff == 0).
  - sf = diff[WIDTH-1].
  - overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the latched operands.
  - The final carry-out is not exported.
- Output hold rule:
  - diff and the flags hold their last completed values through IDLE and the next RUN.
  - They change only on a completing edge or on reset.
  - Partial results are never visible on diff.
- done stays high for exactly one cycle per accepted start. It never asserts without a preceding accepted start.
- Wrap-around: the result is modulo 2^WIDTH with no saturation.

Test Plan:
- Reset, then a=50000, b=50000, start pulse:
  - busy stays high for 8 cycles.
  - done pulses exactly 8 edges after the start edge.
  - diff=0, zf=1, sf=0, overflow=0.
- Borrow chain across chunks:
  - a=0x100, b=1 gives diff=0xFF with all flags 0.
  - a=0, b=1 gives diff=0xFFFF_FFFF_FFFF_FFFF, sf=1, zf=0, overflow=0.
- Signed overflow:
  - a=0x8000_0000_0000_0000, b=1 gives diff=0x7FFF_FFFF_FFFF_FFFF, overflow=1, sf=0.
  - a=0x7FFF_FFFF_FFFF_FFFF, b=-1 gives diff=0x8000_0000_0000_0000, overflow=1, sf=1.
- Operand and start isolation:
  - Start a=10, b=3.
  - While busy, change to a=99, b=1 and pulse start again.
  - Required: a single done, diff=7, and no second operation started.
- Back-to-back: hold start=1 through the done cycle with a=5, b=7 for the second operation.
  - First done reports the first result.
  - Second done follows 9 cycles later with diff=-2, sf=1.
- Reset mid-operation:
  - Drop rst_n at RUN cycle 4.
  - Required: all outputs 0 immediately, no done pulse, and a new start after release completes normally in 8 cycles.

Source files
------------

// File: rtl/sub_64_bit_seq.sv
// Multi-cycle two's-complement subtractor for the Y86 ALU.
// diff = a + ~b + 1, evaluated CHUNK bits per clock with a rippled carry.
// The start/done handshake captures the operands when an operation is
// accepted. diff and the ZF/SF/OF flags change only when an operation
// completes or on reset.
module sub_64_bit_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8     // must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             overflow,
    output logic             zf,
    output logic             sf
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;      // already-inverted subtrahend
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;    // partial result, filled from the top
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             of_q, of_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] nb_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] acc_next;

    // One chunk of a + ~b + carry, and the accumulator with that chunk shifted in.
    // The accumulator shifts right every RUN cycle and the new chunk enters at
    // the top. After N cycles chunk 0 has reached bit 0.
    always_comb begin
        a_chunk  = a_q[idx_q*CHUNK +: CHUNK];
        nb_chunk = nb_q[idx_q*CHUNK +: CHUNK];
        sum      = {1'b0, a_chunk} + {1'b0, nb_chunk} + (CHUNK+1)'(carry_q);
        acc_next = acc_q >> CHUNK;
        acc_next[WIDTH-1 -: CHUNK] = sum[CHUNK-1:0];
    end

    // Control FSM, operand capture and result/flag update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        of_d    = of_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            S_RUN: begin
                acc_d   = acc_next;
                carry_d = sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // The last chunk completes the result. Publish it together with the flags.
                    state_d = S_DONE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = acc_next;
                    zf_d    = (acc_next == '0);
                    sf_d    = acc_next[WIDTH-1];
                    // The sign of b is the inverse of the stored ~b top bit.
                    of_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                              (acc_next[WIDTH-1] != a_q[WIDTH-1]);
                end
            end

            S_DONE: begin
                // busy is low in this cycle, so a new start may be accepted
                // here (back-to-back operation).
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            diff_q  <= '0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign overflow = of_q;
    assign zf       = zf_q;
    assign sf       = sf_q;

endmodule

// File: tb/tb_sub_64_bit_seq.sv
// Directed bench for sub_64_bit_seq. The stimulus pushes the hand-computed
// results into a scoreboard queue. A forked monitor pops one entry on every
// done pulse and checks the value, the flags and the completion cycle.
module tb_sub_64_bit_seq;

    localparam int N = 8;

    typedef struct {
        logic [63:0] diff;
        logic        zf;
        logic        sf;
        logic        of;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] a_i, b_i;
    logic        busy, done, overflow, zf, sf;
    logic [63:0] diff;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    sub_64_bit_seq #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .diff(diff), .overflow(overflow),
        .zf(zf), .sf(sf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Start one operation. Returns one cycle after the start edge, with start low.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ed, input logic ezf, input logic esf, input logic eof);
        @(negedge clk);
        a_i = a; b_i = b; start = 1'b1;
        q.push_back('{ed, ezf, esf, eof, cyc + 1 + N});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int busy_cnt;
        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (done) begin
                    if (q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done: done=1 with no accepted start (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        check("diff", diff, e.diff);
                        check("zf", 64'(zf), 64'(e.zf));
                        check("sf", 64'(sf), 64'(e.sf));
                        check("overflow", 64'(overflow), 64'(e.of));
                        check("done_cycle", 64'(cyc), 64'(e.cyc));
                        check("busy_at_done", 64'(busy), 64'd0);
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_diff", diff, 64'd0);
        check("rst_zf", 64'(zf), 64'd0);
        check("rst_sf", 64'(sf), 64'd0);
        check("rst_of", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands; busy must stay high for exactly N cycles
        issue(64'd50000, 64'd50000, 64'd0, 1'b1, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'd8);
        drain();

        // Borrow chains across chunks
        issue(64'h100, 64'h1, 64'hFF, 1'b0, 1'b0, 1'b0);
        drain();
        issue(64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        drain();

        // Signed overflow in both directions
        issue(64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        drain();
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        drain();

        // Operand and start isolation while busy
        issue(64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a_i = 64'd99; b_i = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("iso_hold_diff", diff, 64'd7);
        check("iso_idle_busy", 64'(busy), 64'd0);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        a_i = 64'd20; b_i = 64'd4; start = 1'b1;
        q.push_back('{64'd16, 1'b0, 1'b0, 1'b0, cyc + 1 + N});
        q.push_back('{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, cyc + 1 + N + N + 1});
        @(negedge clk);
        a_i = 64'd5; b_i = 64'd7;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_hold_diff", diff, 64'd16);
        check("b2b_busy", 64'(busy), 64'd1);
        drain();

        // Reset in the middle of an operation
        @(negedge clk);
        a_i = 64'd1000; b_i = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_diff", diff, 64'd0);
        check("midrst_sf", 64'(sf), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_idle_busy", 64'(busy), 64'd0);
        issue(64'd1000, 64'd1, 64'd999, 1'b0, 1'b0, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
